// File: rtl/nios2e_cpu_debug_pkg.sv
// Shared definitions for the debug command scheduler slice.
//   - Opcode constants for the take_action_*/take_no_action_* strobes.
//   - Scheduler FSM state type.
//   - cmd_t: one queued command {op, data} at the default payload width.
package nios2e_cpu_debug_pkg;

  localparam int unsigned CMD_DW = 38;

  localparam logic [3:0] OP_NONE       = 4'd0;
  localparam logic [3:0] OP_OCIMEM_B   = 4'd1;
  localparam logic [3:0] OP_OCIMEM_A   = 4'd2;
  localparam logic [3:0] OP_BRK_A      = 4'd3;
  localparam logic [3:0] OP_BRK_B      = 4'd4;
  localparam logic [3:0] OP_BRK_C      = 4'd5;
  localparam logic [3:0] OP_TRACECTRL  = 4'd6;
  localparam logic [3:0] OP_NOOCIMEM_A = 4'd7;
  localparam logic [3:0] OP_NOBRK_A    = 4'd8;
  localparam logic [3:0] OP_NOBRK_B    = 4'd9;
  localparam logic [3:0] OP_NOBRK_C    = 4'd10;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  typedef struct packed {
    logic [3:0]        op;
    logic [CMD_DW-1:0] data;
  } cmd_t;

endpackage

// File: rtl/nios2e_cpu_debug_cmd_fifo.sv
// Synchronous command FIFO.
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_push, i_wdata: write one entry (caller must not push when full without popping)
//   i_pop, o_rdata : o_rdata is the head entry; i_pop advances past it
//   o_full, o_empty, o_level: occupancy; level is kept separately from the
//                   pointers so full and empty are distinguishable
module nios2e_cpu_debug_cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 42
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [W-1:0]               i_wdata,
  output logic [W-1:0]               o_rdata,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_level
);

  localparam int unsigned AW = (DEPTH < 2) ? 1 : $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;

  // Storage has no reset; pointers and level define validity.
  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_full  = (r_level == LW'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;

endmodule

// File: rtl/nios2e_cpu_debug_cmd_sched.sv
// Debug command scheduler (sysclk domain).
// Captures take_action_*/take_no_action_* strobes with jdo into a FIFO and
// issues them one at a time to the OCI side over cmd_valid/cmd_ack.
//   clk, reset      : clock, synchronous active-high reset
//   jdo, take_*     : payload and command strobes (opcodes 1..10, lowest wins)
//   cmd_valid/op/data, cmd_ack : issue handshake toward OCI
//   clr_err         : clears sticky err_overflow/err_collision/err_timeout
//   idle, fifo_level: status
module nios2e_cpu_debug_cmd_sched
  import nios2e_cpu_debug_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned DW      = 38
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DW-1:0]          jdo,
  input  logic                   take_action_ocimem_b,
  input  logic                   take_action_ocimem_a,
  input  logic                   take_action_break_a,
  input  logic                   take_action_break_b,
  input  logic                   take_action_break_c,
  input  logic                   take_action_tracectrl,
  input  logic                   take_no_action_ocimem_a,
  input  logic                   take_no_action_break_a,
  input  logic                   take_no_action_break_b,
  input  logic                   take_no_action_break_c,
  output logic                   cmd_valid,
  output logic [3:0]             cmd_op,
  output logic [DW-1:0]          cmd_data,
  input  logic                   cmd_ack,
  input  logic                   clr_err,
  output logic                   idle,
  output logic                   err_overflow,
  output logic                   err_collision,
  output logic                   err_timeout,
  output logic [$clog2(DEPTH):0] fifo_level
);

  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  logic [9:0]    w_strobes;
  logic [3:0]    w_op;
  logic          w_push_req;
  logic          w_collision;
  logic          w_push;
  logic          w_pop;
  logic          w_overflow;
  logic          w_timeout;
  logic          w_full;
  logic          w_empty;
  logic [DW+3:0] w_head;

  state_t        r_state;
  logic          r_cmd_valid;
  logic [3:0]    r_cmd_op;
  logic [DW-1:0] r_cmd_data;
  logic [CW-1:0] r_cnt;
  logic          r_err_overflow;
  logic          r_err_collision;
  logic          r_err_timeout;

  // Bit i carries opcode i+1.
  assign w_strobes = {take_no_action_break_c, take_no_action_break_b,
                      take_no_action_break_a, take_no_action_ocimem_a,
                      take_action_tracectrl,  take_action_break_c,
                      take_action_break_b,    take_action_break_a,
                      take_action_ocimem_a,   take_action_ocimem_b};

  // Scan from the highest opcode down so the lowest set opcode is kept.
  always_comb begin
    w_op = OP_NONE;
    for (int unsigned i = 10; i > 0; i--) begin
      if (w_strobes[i-1]) w_op = 4'(i);
    end
  end

  assign w_push_req  = |w_strobes;
  assign w_collision = (w_strobes & (w_strobes - 10'd1)) != '0;

  // A pop in the same edge frees a slot, so a push into a full FIFO is kept.
  assign w_pop      = (r_state == IDLE) && !w_empty;
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_overflow = w_push_req && w_full && !w_pop;
  assign w_timeout  = (r_state == ISSUE) && !cmd_ack && (TIMEOUT != 0) &&
                      (r_cnt == TO_LAST);

  nios2e_cpu_debug_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (DW + 4)
  ) u_fifo (
    .i_clk   (clk),
    .i_reset (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata ({w_op, jdo}),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cmd_valid <= 1'b0;
      r_cmd_op    <= '0;
      r_cmd_data  <= '0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_cmd_op    <= w_head[DW+3:DW];
            r_cmd_data  <= w_head[DW-1:0];
            r_cnt       <= '0;
            r_cmd_valid <= 1'b1;
            r_state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (cmd_ack || w_timeout) begin
            r_cmd_valid <= 1'b0;
            r_state     <= IDLE;
          end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_cmd_valid <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  // Sticky flags: a new event outranks clr_err in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err_overflow  <= 1'b0;
      r_err_collision <= 1'b0;
      r_err_timeout   <= 1'b0;
    end else begin
      r_err_overflow  <= w_overflow  | (r_err_overflow  & ~clr_err);
      r_err_collision <= w_collision | (r_err_collision & ~clr_err);
      r_err_timeout   <= w_timeout   | (r_err_timeout   & ~clr_err);
    end
  end

  assign cmd_valid     = r_cmd_valid;
  assign cmd_op        = r_cmd_op;
  assign cmd_data      = r_cmd_data;
  assign err_overflow  = r_err_overflow;
  assign err_collision = r_err_collision;
  assign err_timeout   = r_err_timeout;
  assign idle          = (r_state == IDLE) && w_empty;

endmodule

// File: tb/tb_nios2e_cpu_debug_cmd_sched.sv
// Self-checking bench for nios2e_cpu_debug_cmd_sched: directed scenarios plus
// random traffic, all compared against a queue-based reference model.
module tb_nios2e_cpu_debug_cmd_sched;
  import nios2e_cpu_debug_pkg::*;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 8;
  localparam int unsigned DW      = 38;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] jdo;
  logic [9:0]    stb_v;
  logic          cmd_ack, clr_err;
  logic          cmd_valid, idle, err_overflow, err_collision, err_timeout;
  logic [3:0]    cmd_op;
  logic [DW-1:0] cmd_data;
  logic [2:0]    fifo_level;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  nios2e_cpu_debug_cmd_sched #(
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT),
    .DW      (DW)
  ) dut (
    .clk                     (clk),
    .reset                   (reset),
    .jdo                     (jdo),
    .take_action_ocimem_b    (stb_v[0]),
    .take_action_ocimem_a    (stb_v[1]),
    .take_action_break_a     (stb_v[2]),
    .take_action_break_b     (stb_v[3]),
    .take_action_break_c     (stb_v[4]),
    .take_action_tracectrl   (stb_v[5]),
    .take_no_action_ocimem_a (stb_v[6]),
    .take_no_action_break_a  (stb_v[7]),
    .take_no_action_break_b  (stb_v[8]),
    .take_no_action_break_c  (stb_v[9]),
    .cmd_valid               (cmd_valid),
    .cmd_op                  (cmd_op),
    .cmd_data                (cmd_data),
    .cmd_ack                 (cmd_ack),
    .clr_err                 (clr_err),
    .idle                    (idle),
    .err_overflow            (err_overflow),
    .err_collision           (err_collision),
    .err_timeout             (err_timeout),
    .fifo_level              (fifo_level)
  );

  // Reference model: queued commands, one presented command, sticky flags.
  cmd_t mq[$];
  bit   m_busy;
  cmd_t m_cur;
  int   m_age;   // cycles the presented command has been visible
  bit   m_ovf, m_col, m_to;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic model_step(input logic [9:0] stb, input logic [DW-1:0] d,
                            input logic ack, input logic clr, input logic rst);
    bit   ev_ovf, ev_col, ev_to, can_pop;
    cmd_t c;
    ev_ovf = 0; ev_col = 0; ev_to = 0;
    if (rst) begin
      mq.delete(); m_busy = 0; m_cur = '0; m_age = 0;
      m_ovf = 0; m_col = 0; m_to = 0;
      return;
    end
    can_pop = !m_busy && (mq.size() > 0);
    ev_col  = $countones(stb) > 1;
    if (m_busy) begin
      if (ack) m_busy = 0;
      else if (m_age == TIMEOUT) begin m_busy = 0; ev_to = 1; end
      else m_age++;
    end
    if (can_pop) begin
      m_cur = mq.pop_front(); m_busy = 1; m_age = 1;
    end
    if (stb != '0) begin
      c.op = 4'd0;
      for (int i = 0; i < 10; i++) if (stb[i]) begin c.op = 4'(i + 1); break; end
      c.data = d;
      if (mq.size() < DEPTH) mq.push_back(c);
      else ev_ovf = 1;
    end
    m_ovf = ev_ovf || (m_ovf && !clr);
    m_col = ev_col || (m_col && !clr);
    m_to  = ev_to  || (m_to  && !clr);
  endtask

  // One clock: drive at negedge, model at posedge, compare 1 time unit later.
  task automatic cyc(input logic [9:0] stb, input logic [DW-1:0] d,
                     input logic ack, input logic clr, input logic rst);
    @(negedge clk);
    stb_v = stb; jdo = d; cmd_ack = ack; clr_err = clr; reset = rst;
    @(posedge clk);
    model_step(stb, d, ack, clr, rst);
    #1;
    chk("valid", cmd_valid, m_busy);
    chk("level", fifo_level, mq.size());
    chk("idle", idle, !m_busy && mq.size() == 0);
    chk("ovf", err_overflow, m_ovf);
    chk("col", err_collision, m_col);
    chk("tmo", err_timeout, m_to);
    if (m_busy || rst) begin
      chk("op", cmd_op, m_cur.op);
      chk("data", cmd_data, m_cur.data);
    end
  endtask

  function automatic logic [DW-1:0] rnd_d();
    logic [63:0] v;
    v = {$urandom(), $urandom()};
    return v[DW-1:0];
  endfunction

  localparam logic [9:0] S_OCB = 10'b0000000001;
  localparam logic [9:0] S_OCA = 10'b0000000010;
  localparam logic [9:0] S_BA  = 10'b0000000100;
  localparam logic [9:0] S_BB  = 10'b0000001000;
  localparam logic [9:0] S_BC  = 10'b0000010000;
  localparam logic [9:0] S_TC  = 10'b0000100000;
  localparam logic [9:0] S_NBC = 10'b1000000000;

  initial begin
    logic [9:0] seq[5];
    int  got_ops[$];
    int  n;
    logic [9:0] s;
    stb_v = '0; jdo = '0; cmd_ack = 0; clr_err = 0; reset = 1;

    // Reset state
    cyc('0, '0, 0, 0, 1);
    cyc('0, '0, 0, 0, 1);
    chk("rst_valid", cmd_valid, 1'b0);
    chk("rst_idle", idle, 1'b1);
    chk("rst_op", cmd_op, 4'd0);

    // T1: single ocimem_a, ack held high
    cyc(S_OCA, 38'h2A_DEADBEEF, 1, 0, 0);
    chk("t1_v_edgeN", cmd_valid, 1'b0);
    cyc('0, rnd_d(), 1, 0, 0);
    chk("t1_v_edgeN1", cmd_valid, 1'b1);
    chk("t1_op", cmd_op, 4'd2);
    chk("t1_data", cmd_data, 38'h2A_DEADBEEF);
    cyc('0, rnd_d(), 1, 0, 0);
    chk("t1_v_drop", cmd_valid, 1'b0);
    chk("t1_idle", idle, 1'b1);

    // T2: five back-to-back, then a sixth overflows
    seq = '{S_BA, S_BB, S_BC, S_TC, S_OCB};
    foreach (seq[i]) cyc(seq[i], rnd_d(), 0, 0, 0);
    chk("t2_no_ovf", err_overflow, 1'b0);
    chk("t2_lvl4", fifo_level, 3'd4);
    cyc(S_NBC, rnd_d(), 0, 0, 0);
    chk("t2_ovf", err_overflow, 1'b1);
    chk("t2_lvl_full", fifo_level, 3'd4);
    for (int k = 0; k < 40 && got_ops.size() < 5; k++) begin
      if (cmd_valid) begin got_ops.push_back(int'(cmd_op)); cyc('0, rnd_d(), 1, 0, 0); end
      else cyc('0, rnd_d(), 0, 0, 0);
    end
    chk("t2_count", got_ops.size(), 5);
    while (got_ops.size() < 5) got_ops.push_back(-1);
    chk("t2_ord0", got_ops[0], 3);
    chk("t2_ord1", got_ops[1], 4);
    chk("t2_ord2", got_ops[2], 5);
    chk("t2_ord3", got_ops[3], 6);
    chk("t2_ord4", got_ops[4], 1);
    cyc('0, rnd_d(), 0, 1, 0);
    chk("t2_clr", err_overflow, 1'b0);

    // T3: collision break_a + ocimem_b
    cyc(S_BA | S_OCB, rnd_d(), 1, 0, 0);
    chk("t3_col", err_collision, 1'b1);
    chk("t3_lvl", fifo_level, 3'd1);
    cyc('0, rnd_d(), 1, 0, 0);
    chk("t3_op", cmd_op, 4'd1);
    cyc('0, rnd_d(), 1, 0, 0);
    cyc('0, rnd_d(), 0, 1, 0);
    chk("t3_clr", err_collision, 1'b0);

    // T4a: timeout with a single command
    cyc(S_BB, rnd_d(), 0, 0, 0);
    n = 0;
    for (int k = 0; k < 30 && !err_timeout; k++) begin
      cyc('0, rnd_d(), 0, 0, 0);
      if (cmd_valid) n++;
    end
    chk("t4_vlen", n, TIMEOUT);
    chk("t4_tmo", err_timeout, 1'b1);
    chk("t4_idle", idle, 1'b1);
    cyc('0, rnd_d(), 0, 1, 0);
    // T4b: queued command issues normally after a timeout
    cyc(S_BB, rnd_d(), 0, 0, 0);
    cyc(S_TC, rnd_d(), 0, 0, 0);
    for (int k = 0; k < 30 && !err_timeout; k++) cyc('0, rnd_d(), 0, 0, 0);
    chk("t4b_tmo", err_timeout, 1'b1);
    cyc('0, rnd_d(), 0, 0, 0);
    chk("t4b_valid", cmd_valid, 1'b1);
    chk("t4b_op", cmd_op, 4'd6);
    cyc('0, rnd_d(), 1, 1, 0);

    // T5: reset in ISSUE with 3 queued; ack during reset ignored
    cyc(S_BA, rnd_d(), 0, 0, 0);
    cyc(S_BB, rnd_d(), 0, 0, 0);
    cyc(S_BC, rnd_d(), 0, 0, 0);
    cyc(S_TC, rnd_d(), 0, 0, 0);
    chk("t5_pre_lvl", fifo_level, 3'd3);
    cyc('0, rnd_d(), 1, 0, 1);
    chk("t5_valid", cmd_valid, 1'b0);
    chk("t5_lvl", fifo_level, 3'd0);
    chk("t5_idle", idle, 1'b1);
    cyc('0, rnd_d(), 1, 0, 0);
    chk("t5_stay_idle", idle, 1'b1);

    // T6: full FIFO, strobe on the pop edge is accepted
    foreach (seq[i]) cyc(seq[i], rnd_d(), 0, 0, 0);
    cyc('0, rnd_d(), 1, 0, 0);
    chk("t6_lvl_full", fifo_level, 3'd4);
    chk("t6_v0", cmd_valid, 1'b0);
    cyc(S_NBC, rnd_d(), 0, 0, 0);
    chk("t6_lvl", fifo_level, 3'd4);
    chk("t6_ovf", err_overflow, 1'b0);
    chk("t6_v1", cmd_valid, 1'b1);

    // Random traffic against the model
    for (int k = 0; k < 2000; k++) begin
      n = $urandom_range(0, 9);
      if (n < 5) s = '0;
      else if (n < 8) s = 10'd1 << $urandom_range(0, 9);
      else s = 10'($urandom());
      cyc(s, rnd_d(), $urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0,
          $urandom_range(0, 199) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/nios2e_cpu_debug_cmd_sched.md
Name: nios2e_cpu_debug_cmd_sched

Overview:
- Sysclk-domain scheduler between the debug-slave action decoder and the OCI break, ocimem and trace-control register logic.
- Captures single-cycle take_action_*/take_no_action_* strobes together with the 38-bit jdo payload and queues them in a small FIFO.
- Issues queued commands one at a time to the OCI side over a valid/ack handshake, with timeout, overflow and collision error reporting.
- Lets slow OCI consumers never lose back-to-back JTAG commands.

Parameters:
- DEPTH, 4, command FIFO entries; power of 2, 2..16.
- TIMEOUT, 255, max cycles cmd_valid waits for cmd_ack; 0 disables the timeout.
- DW, 38, jdo/payload width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- jdo  in  DW  debug data register payload, sampled with the strobe
- take_action_ocimem_b  in  1  strobe, opcode 1
- take_action_ocimem_a  in  1  strobe, opcode 2
- take_action_break_a  in  1  strobe, opcode 3
- take_action_break_b  in  1  strobe, opcode 4
- take_action_break_c  in  1  strobe, opcode 5
- take_action_tracectrl  in  1  strobe, opcode 6
- take_no_action_ocimem_a  in  1  strobe, opcode 7
- take_no_action_break_a  in  1  strobe, opcode 8
- take_no_action_break_b  in  1  strobe, opcode 9
- take_no_action_break_c  in  1  strobe, opcode 10
- cmd_valid  out  1  command presented to OCI
- cmd_op  out  4  opcode of presented command
- cmd_data  out  DW  payload of presented command
- cmd_ack  in  1  OCI accepted/completed command
- clr_err  in  1  clears sticky error flags
- idle  out  1  FIFO empty and FSM in IDLE
- err_overflow  out  1  sticky: strobe dropped because FIFO was full
- err_collision  out  1  sticky: more than one strobe in the same cycle
- err_timeout  out  1  sticky: command dropped on timeout
- fifo_level  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (sync, active-high) gives: FIFO empty; FSM IDLE; cmd_valid=0; cmd_op=0; cmd_data=0; all err_*=0; fifo_level=0; idle=1.
- Reset asserted mid-transaction discards all queued and in-flight commands. A cmd_ack arriving during reset is ignored.
- Capture: any strobe high at edge N pushes {opcode, jdo} at that edge.
  - Several strobes high together: push only the highest-priority one (lowest opcode) and set err_collision.
- Full: a push when fifo_level==DEPTH with no pop at the same edge is dropped and sets err_overflow.
  - A push and pop at the same edge while full are both accepted; level stays DEPTH.
- Empty: a simultaneous push and pop cannot occur, because the FSM pops only when the FIFO is non-empty before the edge.
- Pointers wrap modulo DEPTH. fifo_level is counted separately so full and empty are distinguishable.
- FSM states: IDLE, ISSUE.
  - IDLE with fifo non-empty: pop the head into the cmd_op/cmd_data holding registers, clear the timeout counter, go to ISSUE.
  - ISSUE: cmd_valid=1; cmd_op and cmd_data are held stable.
  - ISSUE with cmd_ack=1: command complete, go to IDLE. cmd_valid drops on the next cycle.
  - ISSUE with no ack, TIMEOUT!=0 and counter==TIMEOUT-1: drop the command, set err_timeout, go to IDLE.
  - Otherwise stay in ISSUE; the counter saturates.
- Latency: strobe at edge N gives cmd_valid high after edge N+1. Minimum 2 cycles between successive cmd_valid assertions (one IDLE cycle between commands).
- cmd_ack outside ISSUE is ignored.
- clr_err clears all sticky flags at the next edge. An error event in the same cycle as clr_err wins and stays set.
- idle = (state==IDLE) && (fifo_level==0), registered-state derived, no combinational path from the strobes.

Decomposition:
- Shared package nios2e_cpu_debug_pkg holds:
  - opcode constants OP_NONE=0 .. OP_NOBRK_C=10
  - state enum {IDLE, ISSUE}
  - a cmd_t struct {op[3:0], data[DW-1:0]}
- One sub-module, nios2e_cpu_debug_cmd_fifo: synchronous FIFO with push/pop/full/empty/level, no overflow logic inside.
- Priority encoder, FSM and error flags stay in the top module.

Test Plan:
- Single take_action_ocimem_a with jdo=38'h2A_DEADBEEF, cmd_ack held high → cmd_valid high exactly 2 edges after the strobe, one cycle, cmd_op=2, cmd_data=38'h2A_DEADBEEF; then idle=1.
- Five back-to-back strobes (break_a, break_b, break_c, tracectrl, ocimem_b) with DEPTH=4 and cmd_ack=0 → first pops to ISSUE, remaining 4 fill the FIFO, no overflow; a sixth strobe sets err_overflow, fifo_level=4; on acking all commands, opcodes emerge in order 3,4,5,6,1.
- take_action_break_a and take_action_ocimem_b high in the same cycle → one command with cmd_op=1, err_collision=1; then clr_err clears it.
- TIMEOUT=8, one strobe, cmd_ack never asserted → cmd_valid high exactly 8 cycles, then err_timeout=1, idle=1; the next queued command issues normally.
- Reset asserted while in ISSUE with 3 entries queued → next cycle: cmd_valid=0, fifo_level=0, idle=1; a cmd_ack during reset has no effect.
- FIFO full, new strobe coinciding with the FSM pop edge → strobe accepted, err_overflow stays 0, level stays 4.
